// File: rtl/muldiv_if.sv
// muldiv_if: request/result bundle between the core pipeline and the multiply/divide sequencer.
// The core side uses the master modport and the sequencer uses the slave modport.
interface muldiv_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        div0;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, flush, wr_hi, wr_lo, wr_data,
        input  busy, done, div0, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush, wr_hi, wr_lo, wr_data,
        output busy, done, div0, hi, lo
    );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative shift-add multiplier / restoring divider that owns HI/LO.
// op: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
// Optional macro MULDIV_EARLY_OUT_EN: multiply finishes as soon as the multiplier register empties.
module muldiv_seq #(
    parameter logic [31:0] HILO_RST = 32'h00000000
) (
    input  logic    clk,
    input  logic    rst,
    muldiv_if.slave bus
);

    localparam int unsigned W  = 32;
    localparam int unsigned DW = 64;
    localparam int unsigned CW = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [DW-1:0]   r_acc;      // product (multiply) or remainder in [32:0] (divide)
    logic [DW-1:0]   r_mcand;    // multiplicand (multiply) or divisor in [31:0] (divide)
    logic [W-1:0]    r_mplier;   // multiplier (multiply) or dividend/quotient (divide)
    logic            r_is_div;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_div0;
    logic            r_busy;
    logic            r_done;
    logic            r_div0_p;
    logic [W-1:0]    r_hi;
    logic [W-1:0]    r_lo;

    logic            w_accept;
    logic            w_iter;
    logic            w_fin_wr;
    logic            w_early;
    logic            w_sa;
    logic            w_sb;
    logic [W-1:0]    w_a_mag;
    logic [W-1:0]    w_b_mag;
    logic [W:0]      w_rem_sh;
    logic [W:0]      w_rem_sub;
    logic            w_rem_ge;
    logic [W-1:0]    w_res_hi;
    logic [W-1:0]    w_res_lo;
    logic [DW-1:0]   w_prod;

    // Operand signs and magnitudes; unsigned ops never see a sign.
    assign w_sa    = bus.op[0] & bus.a[W-1];
    assign w_sb    = bus.op[0] & bus.b[W-1];
    assign w_a_mag = w_sa ? (W'(0) - bus.a) : bus.a;
    assign w_b_mag = w_sb ? (W'(0) - bus.b) : bus.b;

    // Restoring-divide step: shift in the next dividend bit and trial-subtract.
    assign w_rem_sh  = {r_acc[W-1:0], r_mplier[W-1]};
    assign w_rem_ge  = (w_rem_sh >= {1'b0, r_mcand[W-1:0]});
    assign w_rem_sub = w_rem_sh - {1'b0, r_mcand[W-1:0]};

    // Early exit when no multiplier bits remain (multiply only).
`ifdef MULDIV_EARLY_OUT_EN
    assign w_early = ~r_is_div & (r_mplier == '0);
`else
    assign w_early = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control strobes; flush wins over start and over the FIN write.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_iter      = 1'b0;
        w_fin_wr    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (bus.op[1] && (bus.b == '0)) ? S_FIN : S_RUN;
                end
            end
            S_RUN: begin
                if (bus.flush) begin
                    w_state_nxt = S_IDLE;
                end else if (w_early) begin
                    w_state_nxt = S_FIN;
                end else begin
                    w_iter = 1'b1;
                    if (r_cnt == CW'(31)) begin
                        w_state_nxt = S_FIN;
                    end
                end
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
                if (!bus.flush) begin
                    w_fin_wr = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Sign-corrected results presented at the FIN edge.
    always_comb begin
        w_prod   = r_neg_q ? (DW'(0) - r_acc) : r_acc;
        w_res_hi = w_prod[DW-1:W];
        w_res_lo = w_prod[W-1:0];
        if (r_is_div) begin
            w_res_lo = r_neg_q ? (W'(0) - r_mplier) : r_mplier;
            w_res_hi = r_neg_r ? (W'(0) - r_acc[W-1:0]) : r_acc[W-1:0];
        end
    end

    // Shared iterative datapath: operand latch on accept, one step per RUN edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_is_div <= bus.op[1];
            r_neg_q  <= w_sa ^ w_sb;
            r_neg_r  <= w_sa;
            r_div0   <= bus.op[1] & (bus.b == '0);
            if (bus.op[1]) begin
                r_mcand  <= {W'(0), w_b_mag};
                r_mplier <= w_a_mag;
            end else begin
                r_mcand  <= {W'(0), w_a_mag};
                r_mplier <= w_b_mag;
            end
        end else if (w_iter) begin
            r_cnt <= r_cnt + CW'(1);
            if (r_is_div) begin
                r_acc    <= {(DW-W-1)'(0), (w_rem_ge ? w_rem_sub : w_rem_sh)};
                r_mplier <= {r_mplier[W-2:0], w_rem_ge};
            end else begin
                if (r_mplier[0]) begin
                    r_acc <= r_acc + r_mcand;
                end
                r_mcand  <= {r_mcand[DW-2:0], 1'b0};
                r_mplier <= {1'b0, r_mplier[W-1:1]};
            end
        end
    end

    // Architectural HI/LO: FIN result, otherwise MTHI/MTLO while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi <= HILO_RST;
            r_lo <= HILO_RST;
        end else if (w_fin_wr) begin
            if (!r_div0) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end
        end else if (r_state == S_IDLE) begin
            if (bus.wr_hi) begin
                r_hi <= bus.wr_data;
            end
            if (bus.wr_lo) begin
                r_lo <= bus.wr_data;
            end
        end
    end

    // Registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_div0_p <= 1'b0;
        end else begin
            r_busy   <= (w_state_nxt != S_IDLE);
            r_done   <= w_fin_wr;
            r_div0_p <= w_fin_wr & r_div0;
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.div0 = r_div0_p;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vectors and multi-cycle corner sequences for muldiv_seq.
module tb_muldiv_seq;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    muldiv_if bus_if ();

    muldiv_seq #(.HILO_RST(32'h00000000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Expected edges from accept to done.
    function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
        int lat;
        lat = 33;
        if (op[1] && (b == 32'd0)) lat = 1;
`ifdef MULDIV_EARLY_OUT_EN
        if (!op[1]) begin
            logic [31:0] m;
            int k;
            m = (op[0] && b[31]) ? (32'd0 - b) : b;
            k = 0;
            for (int j = 0; j < 32; j++) if (m[j]) k = j + 1;
            lat = (k + 2 < 33) ? k + 2 : 33;
        end
`endif
        return lat;
    endfunction

    // Issue a request and step through the accept edge.
    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus_if.op    = op;
        bus_if.a     = a;
        bus_if.b     = b;
        bus_if.start = 1'b1;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
    endtask

    // Wait (bounded) for done; lat=0 means it never came.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (bus_if.done) begin
                lat = n;
                break;
            end
            if (bus_if.busy) bcnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int bc;
        int el;

        vecs[0] = '{2'b01, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2] = '{2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{2'b10, 32'd100,      32'd7,        32'h00000002, 32'h0000000E};
        vecs[4] = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5] = '{2'b00, 32'd5,        32'd3,        32'h00000000, 32'h0000000F};
        vecs[6] = '{2'b11, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[7] = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[8] = '{2'b00, 32'h00001234, 32'd0,        32'h00000000, 32'h00000000};
        vecs[9] = '{2'b00, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780};

        bus_if.start   = 1'b0;
        bus_if.op      = 2'b00;
        bus_if.a       = '0;
        bus_if.b       = '0;
        bus_if.flush   = 1'b0;
        bus_if.wr_hi   = 1'b0;
        bus_if.wr_lo   = 1'b0;
        bus_if.wr_data = '0;
        rst = 1'b1;

        // Reset state while reset is held.
        #12;
        chk("rst_busy", 64'(bus_if.busy), 64'd0);
        chk("rst_done", 64'(bus_if.done), 64'd0);
        chk("rst_div0", 64'(bus_if.div0), 64'd0);
        chk("rst_hi",   64'(bus_if.hi),   64'h0);
        chk("rst_lo",   64'(bus_if.lo),   64'h0);
        #4 rst = 1'b0;
        @(posedge clk); #1;

        // Table of arithmetic vectors.
        for (int i = 0; i < 10; i++) begin
            el = exp_lat(vecs[i].op, vecs[i].b);
            launch(vecs[i].op, vecs[i].a, vecs[i].b);
            chk($sformatf("v%0d_busy_e0", i), 64'(bus_if.busy), 64'd1);
            wait_done(lat, bc);
            chk($sformatf("v%0d_lat", i),       64'(lat),          64'(el));
            chk($sformatf("v%0d_busy_cnt", i),  64'(bc),           64'(el - 1));
            chk($sformatf("v%0d_busy_done", i), 64'(bus_if.busy),  64'd0);
            chk($sformatf("v%0d_div0", i),      64'(bus_if.div0),  64'd0);
            chk($sformatf("v%0d_hi", i),        64'(bus_if.hi),    64'(vecs[i].hi));
            chk($sformatf("v%0d_lo", i),        64'(bus_if.lo),    64'(vecs[i].lo));
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_pulse", i), 64'(bus_if.done), 64'd0);
        end

        // Divide by zero with HI/LO preloaded through MTHI/MTLO.
        bus_if.wr_hi = 1'b1; bus_if.wr_data = 32'h11;
        @(posedge clk); #1;
        bus_if.wr_hi = 1'b0; bus_if.wr_lo = 1'b1; bus_if.wr_data = 32'h22;
        @(posedge clk); #1;
        bus_if.wr_lo = 1'b0;
        chk("mthi", 64'(bus_if.hi), 64'h11);
        chk("mtlo", 64'(bus_if.lo), 64'h22);
        launch(2'b10, 32'd5, 32'd0);
        chk("dz_busy_e0", 64'(bus_if.busy), 64'd1);
        wait_done(lat, bc);
        chk("dz_lat",  64'(lat),         64'd1);
        chk("dz_div0", 64'(bus_if.div0), 64'd1);
        chk("dz_busy", 64'(bus_if.busy), 64'd0);
        chk("dz_hi",   64'(bus_if.hi),   64'h11);
        chk("dz_lo",   64'(bus_if.lo),   64'h22);
        @(posedge clk); #1;
        chk("dz_done_pulse", 64'(bus_if.done), 64'd0);
        chk("dz_div0_pulse", 64'(bus_if.div0), 64'd0);

        // Flush at E10; start at E5 and MTHI at E7 are ignored while busy.
        launch(2'b10, 32'd100, 32'd7);
        for (int n = 1; n <= 10; n++) begin
            bus_if.start   = (n == 5);
            bus_if.op      = 2'b00;
            bus_if.a       = 32'd3;
            bus_if.b       = 32'd3;
            bus_if.wr_hi   = (n == 7);
            bus_if.wr_data = 32'hDEADBEEF;
            bus_if.flush   = (n == 10);
            @(posedge clk); #1;
            if (n == 9) chk("fl_busy_before", 64'(bus_if.busy), 64'd1);
        end
        bus_if.start = 1'b0; bus_if.wr_hi = 1'b0; bus_if.flush = 1'b0;
        chk("fl_busy_after", 64'(bus_if.busy), 64'd0);
        wait_done(lat, bc);
        chk("fl_no_done", 64'(lat),       64'd0);
        chk("fl_hi",      64'(bus_if.hi), 64'h11);
        chk("fl_lo",      64'(bus_if.lo), 64'h22);

        // MTHI in the accept cycle, then back-to-back start while done is high.
        bus_if.wr_hi = 1'b1; bus_if.wr_data = 32'hCAFEF00D;
        launch(2'b00, 32'd5, 32'd3);
        bus_if.wr_hi = 1'b0;
        chk("mt_start_hi",   64'(bus_if.hi),   64'hCAFEF00D);
        chk("mt_start_busy", 64'(bus_if.busy), 64'd1);
        wait_done(lat, bc);
        chk("mt_start_lat", 64'(lat),       64'(exp_lat(2'b00, 32'd3)));
        chk("mt_start_res_hi", 64'(bus_if.hi), 64'h0);
        chk("mt_start_res_lo", 64'(bus_if.lo), 64'hF);
        launch(2'b10, 32'd100, 32'd7);
        chk("b2b_busy", 64'(bus_if.busy), 64'd1);
        wait_done(lat, bc);
        chk("b2b_lat", 64'(lat),       64'd33);
        chk("b2b_hi",  64'(bus_if.hi), 64'h2);
        chk("b2b_lo",  64'(bus_if.lo), 64'hE);

        // Asynchronous reset in the middle of an operation.
        launch(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (20) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_busy", 64'(bus_if.busy), 64'd0);
        chk("arst_hi",   64'(bus_if.hi),   64'h0);
        chk("arst_lo",   64'(bus_if.lo),   64'h0);
        #2 rst = 1'b0;
        wait_done(lat, bc);
        chk("arst_no_done", 64'(lat), 64'd0);

        // Recovery after reset.
        launch(2'b01, 32'hFFFFFFFD, 32'd7);
        wait_done(lat, bc);
        chk("post_lat", 64'(lat),       64'd33);
        chk("post_hi",  64'(bus_if.hi), 64'hFFFFFFFF);
        chk("post_lo",  64'(bus_if.lo), 64'hFFFFFFEB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
